rf_wb_arbiter: RTL

Arbiter and sequencer for the shared single write port of the 32×64-bit general register file. It merges writebacks from the ALU path and the load/store unit onto one registered write port. ALU results are buffered in a small FIFO, with a starvation guard. On an `ebreak` halt request the block drains pending writes, so the simulator sees a fully committed register state before it stops.

---
 rtl/rf_wb_arbiter.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// Write-port arbiter for the 32x64 register file: merges ALU and LSU writebacks onto one
// registered port, buffers ALU results with a starvation guard, drains on halt. Option: RF_WB_ARB_PERF_EN.
module rf_wb_arbiter #(
    parameter int XLEN         = 64,
    parameter int AW           = 5,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            halt_req,
    output logic            halt_done,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            busy
`ifdef RF_WB_ARB_PERF_EN
    ,
    output logic [31:0]     conflict_cnt
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE,
        WIN_HEAD,
        WIN_LSU,
        WIN_ALU
    } win_t;

    state_t          state;
    win_t            win;
    logic [PW:0]     wr_ptr;
    logic [PW:0]     rd_ptr;
    logic [AW-1:0]   fifo_rd   [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_data [FIFO_DEPTH];
    logic [SW-1:0]   starve_cnt;

    logic            fifo_empty;
    logic            fifo_full;
    logic            force_head;
    logic            alu_acc;
    logic            lsu_acc;
    logic            push;
    logic            pop;
    logic [AW-1:0]   win_rd;
    logic [XLEN-1:0] win_data;

    // The extra pointer MSB tells a full ring from an empty one.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign force_head = !fifo_empty && (starve_cnt == STARVE_MAX);

    assign alu_ready = (state == ST_RUN) && !fifo_full;
    assign lsu_ready = (state != ST_HALTED) && !force_head;
    assign alu_acc   = alu_valid && alu_ready;
    assign lsu_acc   = lsu_valid && lsu_ready;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        win = WIN_NONE;
        if (force_head) begin
            win = WIN_HEAD;
        end else if (lsu_acc) begin
            win = WIN_LSU;
        end else if (!fifo_empty) begin
            win = WIN_HEAD;
        end else if (alu_acc) begin
            win = WIN_ALU;
        end
    end

    always_comb begin
        win_rd   = '0;
        win_data = '0;
        case (win)
            WIN_HEAD: begin
                win_rd   = fifo_rd[rd_ptr[PW-1:0]];
                win_data = fifo_data[rd_ptr[PW-1:0]];
            end
            WIN_LSU: begin
                win_rd   = lsu_rd;
                win_data = lsu_data;
            end
            WIN_ALU: begin
                win_rd   = alu_rd;
                win_data = alu_data;
            end
            default: begin
                win_rd   = '0;
                win_data = '0;
            end
        endcase
    end

    assign pop  = (win == WIN_HEAD);
    assign push = alu_acc && (win != WIN_ALU);

    // NOTE: the storage array carries no reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr[PW-1:0]]   <= alu_rd;
            fifo_data[wr_ptr[PW-1:0]] <= alu_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // An ALU entry that loses on the cycle it is pushed has already waited one cycle,
    // so an empty FIFO that is being filled still counts toward the starvation limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (pop || (fifo_empty && !push)) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Writes to x0 are consumed but never enabled on the port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we    <= (win != WIN_NONE) && (win_rd != '0);
            rf_waddr <= win_rd;
            rf_wdata <= win_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            halt_done <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (halt_req) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty && !lsu_valid) begin
                        state     <= ST_HALTED;
                        halt_done <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    state     <= ST_HALTED;
                    halt_done <= 1'b1;
                end
                default: begin
                    state     <= ST_RUN;
                    halt_done <= 1'b0;
                end
            endcase
        end
    end

    assign busy = !fifo_empty || rf_we;

`ifdef RF_WB_ARB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (lsu_valid && !fifo_empty && (conflict_cnt != 32'hFFFF_FFFF)) begin
            conflict_cnt <= conflict_cnt + 32'd1;
        end
    end
`endif

    a_no_push_when_full : assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));
    a_no_pop_when_empty : assert property (@(posedge clk) disable iff (rst) !(pop && fifo_empty));
    a_halted_is_quiet   : assert property (@(posedge clk) disable iff (rst) halt_done |-> (fifo_empty && !rf_we));

endmodule
